// File: rtl/mem_resp_sram.sv
// mem_resp_sram
// Far-end responder for the mcore external memory port. Accepts word
// requests, performs byte-enabled writes into an internal word array and
// returns exactly one in-order response per accepted request, visible from
// the RD_LATENCY-th edge after acceptance.
//
// Ports:
//   aclk, areset        clock (rising edge) and synchronous active-high reset
//   mem_req             request valid; accepted when mem_req && mem_gnt
//   mem_addr            byte address
//   mem_we              1 = write, 0 = read
//   mem_wdata, mem_be   write data and byte enables (writes only)
//   mem_gnt             registered grant
//   mem_rsp_valid       one-cycle response strobe per accepted request
//   mem_rsp_rdata       read data; 0 for writes and errors
//   mem_rsp_error       misaligned or out-of-range request
//
// Optional feature: define MEM_RESP_STALL_EN to drive the grant from a
// 16-bit LFSR (seed 0xACE1) that withholds grant about 25% of cycles.
module mem_resp_sram #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    mem_req,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_we,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    mem_gnt,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
  output logic                    mem_rsp_error
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W:0] DEPTH_IDX = (IDX_W + 1)'(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic              gnt;
  logic              acc;
  logic              err;
  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] waddr;

  logic                  vld_p0;
  logic                  err_p0;
  logic [DATA_WIDTH-1:0] dat_p0;
  logic                  vld_pn [RD_LATENCY];
  logic                  err_pn [RD_LATENCY];
  logic [DATA_WIDTH-1:0] dat_pn [RD_LATENCY];

  // A request seen on the reset edge is never accepted.
  assign acc   = mem_req && gnt && !areset;
  assign idx   = mem_addr[ADDR_WIDTH-1:OFF_W];
  assign waddr = idx[MEM_AW-1:0];
  assign err   = (mem_addr[OFF_W-1:0] != '0) || ({1'b0, idx} >= DEPTH_IDX);

  // Array: no reset, contents survive areset.
  always_ff @(posedge aclk) begin
    if (acc && mem_we && !err) begin
      for (int k = 0; k < BE_W; k++) begin
        if (mem_be[k]) mem[waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  // Stage p0: capture on the acceptance edge (read sees earlier-edge writes)
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_p0 <= 1'b0;
      err_p0 <= 1'b0;
      dat_p0 <= '0;
    end else begin
      vld_p0 <= acc;
      err_p0 <= acc && err;
      dat_p0 <= (acc && !mem_we && !err) ? mem[waddr] : '0;
    end
  end

  // Stages pn: RD_LATENCY-deep response shift register
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_pn[i] <= 1'b0;
        err_pn[i] <= 1'b0;
        dat_pn[i] <= '0;
      end
    end else begin
      vld_pn[0] <= vld_p0;
      err_pn[0] <= err_p0;
      dat_pn[0] <= dat_p0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pn[i] <= vld_pn[i-1];
        err_pn[i] <= err_pn[i-1];
        dat_pn[i] <= dat_pn[i-1];
      end
    end
  end

  assign mem_rsp_valid = vld_pn[RD_LATENCY-1];
  assign mem_rsp_error = err_pn[RD_LATENCY-1];
  assign mem_rsp_rdata = dat_pn[RD_LATENCY-1];
  assign mem_gnt       = gnt;

`ifdef MEM_RESP_STALL_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign lfsr_nxt = lfsr_step(lfsr);

  // Grant is registered alongside the LFSR state it is derived from.
  always_ff @(posedge aclk) begin
    if (areset) begin
      lfsr <= 16'hACE1;
      gnt  <= 1'b0;
    end else begin
      lfsr <= lfsr_nxt;
      gnt  <= (lfsr_nxt[1:0] != 2'b00);
    end
  end
`else
  always_ff @(posedge aclk) begin
    if (areset) gnt <= 1'b0;
    else        gnt <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_resp_sram.sv
module tb_mem_resp_sram;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic          aclk = 1'b0;
  logic          areset;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_gnt;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;
  logic          mem_rsp_error;

  mem_resp_sram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT)
  ) dut (
    .aclk(aclk), .areset(areset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_error(mem_rsp_error)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          acc_cnt = 0;
  int          dut_rsp = 0;
  logic        gnt_m = 1'b0;
  logic [15:0] lfsr_m = 16'hACE1;
  logic        last_acc = 1'b0;
  logic        use_exp = 1'b0;
  logic [31:0] exp_word = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, got, want);
    end
  endtask

  // One clock: update the reference model on the edge, then check outputs.
  task automatic tick();
    exp_t        e;
    logic [29:0] idx;
    logic        err;
    logic        exp_v;
    @(posedge aclk);
    cyc++;
    last_acc = mem_req && gnt_m && !areset;
    if (last_acc) begin
      idx    = mem_addr[31:2];
      err    = (mem_addr[1:0] != 2'b00) || (idx >= 30'(DEPTH));
      e.due  = cyc + LAT;
      e.err  = err;
      e.data = '0;
      if (!err && mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) mem_m[idx[9:0]][8*k +: 8] = mem_wdata[8*k +: 8];
      end else if (!err) begin
        e.data = use_exp ? exp_word : mem_m[idx[9:0]];
      end
      sb.push_back(e);
      acc_cnt++;
    end
    if (areset) begin
      sb.delete();
      gnt_m  = 1'b0;
      lfsr_m = 16'hACE1;
    end else begin
`ifdef MEM_RESP_STALL_EN
      lfsr_m = {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
      gnt_m  = (lfsr_m[1:0] != 2'b00);
`else
      gnt_m  = 1'b1;
`endif
    end
    #1;
    if (mem_rsp_valid === 1'b1) dut_rsp++;
    chk("gnt", 32'(mem_gnt), 32'(gnt_m));
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    chk("rsp_valid", 32'(mem_rsp_valid), 32'(exp_v));
    if (exp_v) begin
      e = sb.pop_front();
      chk("rsp_rdata", mem_rsp_rdata, e.data);
      chk("rsp_error", 32'(mem_rsp_error), 32'(e.err));
    end
    if (areset) begin
      chk("rst_rdata", mem_rsp_rdata, 32'h0);
      chk("rst_error", 32'(mem_rsp_error), 32'h0);
    end
  endtask

  // Present a request and hold it until accepted; req stays high afterwards.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic ue, input logic [31:0] ew);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wd;
    mem_be    = be;
    use_exp   = ue;
    exp_word  = ew;
    for (int t = 0; t < 64; t++) begin
      tick();
      if (last_acc) break;
    end
    chk("accept_timeout", 32'(last_acc), 32'h1);
    use_exp = 1'b0;
  endtask

  task automatic idle(input int n);
    mem_req = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int          start;
    logic [31:0] a;
    int          w;
    int          sel;
    areset = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_be = '0;
    repeat (3) tick();
    areset = 1'b0;
    idle(2);

    // Write then read-after-write on the next cycle
    issue(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
    idle(4);

    // Byte enables
    issue(1'b1, 32'h80, 32'h11223344, 4'hF, 1'b0, 32'h0);
    issue(1'b1, 32'h80, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0);
    issue(1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 32'h11BB33DD);
    idle(4);

    // Errors leave the array untouched; be=0 write is a responding no-op
    issue(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
    issue(1'b0, 32'h1002, 32'h0, 4'h0, 1'b0, 32'h0);
    issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    issue(1'b1, 32'h0, 32'h12345678, 4'h0, 1'b0, 32'h0);
    issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0BADF00D);
    idle(4);

    // Streaming: preload words 0..15 then 16 back-to-back reads
    for (int i = 0; i < 16; i++)
      issue(1'b1, 32'(4*i), 32'hC0DE0000 ^ (32'h01010101 * 32'(i)), 4'hF, 1'b0, 32'h0);
    idle(2);
    for (int i = 0; i < 16; i++)
      issue(1'b0, 32'(4*i), 32'h0, 4'h0, 1'b1, 32'hC0DE0000 ^ (32'h01010101 * 32'(i)));
    idle(4);

    // Reset mid-flight: in-flight responses dropped, write stays committed
    issue(1'b1, 32'h10, 32'h5A5AA5A5, 4'hF, 1'b0, 32'h0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0);
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    mem_req = 1'b0;
    tick();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h5A5AA5A5);
    idle(4);

    // Random traffic over preloaded words, with occasional errors
    acc_cnt = 0;
    dut_rsp = 0;
    start = cyc;
    while (cyc < start + 1000) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        w   = $urandom_range(0, 15);
        sel = $urandom_range(0, 9);
        a   = (sel == 0) ? 32'(4*w + 1) : (sel == 1) ? 32'(32'h1000 + 4*w) : 32'(4*w);
        issue(1'(($urandom_range(0, 1))), a, $urandom, 4'($urandom_range(0, 15)), 1'b0, 32'h0);
      end
    end
    idle(LAT + 3);
    chk("rsp_count", 32'(dut_rsp), 32'(acc_cnt));
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_resp_sram.md
# mem_resp_sram

Synthesizable responder for the mcore external memory port (`mem_req`/`mem_gnt`/`mem_rsp_*`). It is the far end of the interface the mcore drives. It accepts word requests, performs byte-enabled writes into an internal word array, and returns exactly one in-order response per accepted request after a fixed latency. It replaces the behavioural memory model in on-chip integration and gives a cycle-exact target for mcore bring-up. An optional grant-stall generator exercises initiator back-pressure.

## Interface
- DATA_WIDTH, 32, data bus width; a multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- DEPTH_WORDS, 1024, number of DATA_WIDTH-bit words in the array.
- RD_LATENCY, 2, cycles from acceptance to response; legal range 1..8.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  reset; synchronous, active-high.
- mem_req  in  1  request valid.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_we  in  1  1 = write, 0 = read.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_be  in  DATA_WIDTH/8  byte enables; used on writes only.
- mem_gnt  out  1  grant; registered.
- mem_rsp_valid  out  1  response valid, one per accepted request.
- mem_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- mem_rsp_error  out  1  error flag, qualified by mem_rsp_valid.

## Operation
- **Acceptance:** a request is accepted on a rising edge where `mem_req && mem_gnt`. The initiator holds all request fields stable until accepted.
- **Address decode:** word index = `mem_addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]`.
- **Error condition:** any of the following sets error.
  - Low address bits are non-zero (misaligned).
  - Word index >= DEPTH_WORDS.
- **Error response:** the request is still accepted and still gets a response with `rsp_error=1` and `rdata=0`. The array is not modified.
- **Write:** on the acceptance edge, byte k of the word is updated iff `mem_be[k]`. `be=0` is a legal no-op that still responds. The response has `rdata=0` and `error=0`.
- **Read:** the array word is sampled on the acceptance edge, after any write committed on an earlier edge.
  - A read accepted one cycle after a write to the same word returns the new data.
  - Reads and writes are never accepted on the same edge, since there is one port.
- **Response pipeline:** shift register of {valid, error, rdata}, RD_LATENCY stages deep. Strict order, no reordering, throughput one request per cycle.
- **No response back-pressure:** the initiator always accepts `mem_rsp_valid`.
- **Grant:** `mem_gnt` is 1 every cycle out of reset, unless modified by the Configuration feature.
- **Array initialization:** none. Contents are not cleared by reset; the bench preloads via writes.

## Timing
- **Reset values:** while `areset` is high, `mem_gnt=0`, `mem_rsp_valid=0`, `mem_rsp_rdata=0`, `mem_rsp_error=0`, and all pipeline stages are cleared. `mem_gnt` rises one edge after `areset` is sampled low.
- **Latency:** a request accepted at edge N has its response visible from edge N+RD_LATENCY for exactly one cycle. With RD_LATENCY=1 the response appears in the cycle immediately after acceptance.
- **Back-to-back:** requests accepted on consecutive edges produce responses on consecutive cycles.
- **Reset mid-operation:**
  - In-flight responses are discarded and none are emitted after reset.
  - Writes accepted before the reset edge remain committed.
  - A request presented on the reset edge is not accepted.
- **Request while grant is low:** the request is not accepted and no response is generated. The initiator keeps `mem_req` asserted.

## Configuration
- **MEM_RESP_STALL_EN defined:** a 16-bit Fibonacci LFSR (taps 16,14,13,11) drives the grant.
  - Seeded to 0xACE1 on reset; advances every cycle out of reset.
  - `mem_gnt` is registered as 0 in cycles where the LFSR state has `[1:0]==2'b00`, giving about 25% stall cycles with a deterministic pattern per seed.
  - Latency from acceptance is unchanged.
- **MEM_RESP_STALL_EN not defined:** no LFSR logic is generated and `mem_gnt=1` every cycle out of reset.

## Test plan
- **Write then read, RD_LATENCY=2:**
  - Stimulus: write 0xDEADBEEF to 0x40 with be=0xF, then read 0x40 on the next cycle.
  - Response: write response at N+2 (rdata=0, error=0); read response at N+3 with rdata=0xDEADBEEF.
- **Byte enables:**
  - Stimulus: preload 0x11223344 at 0x80, write 0xAABBCCDD with be=0x5, then read 0x80.
  - Response: rdata=0x11BB33DD.
- **Errors:**
  - Stimulus: read 0x1002 (misaligned), then write to 0x1000 (index 1024, DEPTH_WORDS=1024).
  - Response: both respond with error=1 and rdata=0; a subsequent read of index 0 is unchanged.
- **Streaming:**
  - Stimulus: 16 consecutive reads of preloaded words 0..15, req held high.
  - Response: 16 consecutive rsp_valid cycles, in order, first at N+RD_LATENCY, with correct data.
- **Reset mid-flight:**
  - Stimulus: accept a write to 0x10 and a read at edges N and N+1, then assert areset at N+2 for 2 cycles.
  - Response: no responses emitted; gnt=0 during reset; after release, a read of 0x10 returns the written data.
- **Stall (with MEM_RESP_STALL_EN):**
  - Stimulus: 1000-cycle random traffic.
  - Response: the gnt pattern matches the LFSR reference model from seed 0xACE1; response count equals accept count; no response is generated for an unaccepted cycle.
